ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Multi-master AHB bus arbiter that sits directly downstream of the CPU-side AHB master interfaces. It consumes each master's `M_HBUSREQ` and returns `M_HGRANT`. It also publishes the address-phase owner (`HMASTER`) and the data-phase owner (`HMASTER_D`), which drive the fabric's address/control and write-data multiplexers. Grant is round-robin with a parked default master and a tenure limit, so a master that holds `M_HBUSREQ` continuously cannot starve the others.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters; legal range 2..8.
- `DEFAULT_MASTER`, 0: index granted when nobody requests, and after reset.
- `MAX_TENURE`, 16: completed transfers a master may hold the bus while another request is pending; legal range 1..255.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `M_HBUSREQ` in NUM_MASTERS: per-master bus request; bit i belongs to master i.
- `HREADY` in 1: transfer-complete signal from the slave mux; no grant or owner change happens while it is low.
- `HTRANS` in 2: transfer type from the address-phase owner (already muxed).
- `M_HGRANT` out NUM_MASTERS: one-hot grant; exactly one bit is set at all times.
- `HMASTER` out 4: index of the address-phase owner.
- `HMASTER_D` out 4: index of the data-phase owner.

## Operation
- The FSM has two states, `PARK` and `OWN`, encoded as constants.
  - In `PARK`, `DEFAULT_MASTER` is granted and no request is being serviced.
  - In `OWN`, the master `cur` holds the grant on behalf of its own request.
- A decision point is any rising edge with `HREADY`=1. Nothing changes on edges where `HREADY`=0.
- `PARK` at a decision point:
  - If any `M_HBUSREQ` bit is set, grant the winner of a round-robin search starting at (`last`+1) mod `NUM_MASTERS`, and go to `OWN`.
  - Otherwise stay in `PARK` with the grant unchanged.
- `OWN` at a decision point, re-arbitrate when either condition holds:
  - (a) `M_HBUSREQ[cur]`=0;
  - (b) `tenure`=`MAX_TENURE` and some other request bit is set.
- Re-arbitration:
  - The search starts at `cur`+1. `cur` itself is eligible last, and only in case (a) if its request is set again.
  - If no request is set, go to `PARK` with `DEFAULT_MASTER` granted.
- `last` is set to the index of each new owner on entry to `OWN`.
- `tenure` counter (8 bits):
  - cleared on every grant change;
  - increments at each decision point in `OWN` where `HTRANS` is NONSEQ (2'b10) or SEQ (2'b11);
  - saturates at `MAX_TENURE`.
- Owner pipeline:
  - `HMASTER` takes the index of the granted master at each decision point;
  - `HMASTER_D` takes the previous `HMASTER` at each decision point.
- Reset state:
  - `M_HGRANT` = one-hot `DEFAULT_MASTER`;
  - `HMASTER` = `HMASTER_D` = `DEFAULT_MASTER`;
  - state = `PARK`; `tenure` = 0; `last` = `DEFAULT_MASTER`.
- Reset asserted mid-operation returns everything to the reset state immediately, regardless of `HREADY`. In-flight transfers are abandoned.
- Request bits at indices ≥ `NUM_MASTERS` do not exist. The `HMASTER` upper bits are always 0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Request-to-grant latency:
  - from `PARK`, 1 cycle: request sampled at edge N with `HREADY`=1 gives `M_HGRANT` at edge N;
  - `HMASTER` follows on the next decision point (edge N+1 or later).
- While `HREADY`=0, `M_HGRANT`, `HMASTER`, `HMASTER_D`, `tenure` and state all hold. Requests raised or dropped during wait states are evaluated at the first edge where `HREADY`=1.
- If requests from several masters first rise in the same cycle, round-robin order decides the winner.
- A request dropped and re-raised in the same cycle counts as held.

## Structure
- A shared package `ahb_defs` holds:
  - the HTRANS encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11);
  - the FSM state constants `PARK` and `OWN`;
  - the HMASTER width (4).
- One sub-module is natural: `rr_pick`, a combinational round-robin priority encoder.
  - Inputs: request vector and start index.
  - Outputs: winner index and valid flag.

## Test plan
- **Reset:** assert `rst` with `DEFAULT_MASTER`=0 → `M_HGRANT`=4'b0001, `HMASTER`=`HMASTER_D`=0. Deassert with no requests → values held for 10 cycles.
- **Single request:** `M_HBUSREQ`=4'b0100, `HREADY`=1 → `M_HGRANT`=4'b0100 after 1 edge, `HMASTER`=2 one edge later, `HMASTER_D`=2 one edge after that.
- **Simultaneous requests from `PARK`:** `last`=0, `M_HBUSREQ`=4'b1011 → grant order 1, 3, 0, each master dropping its request after one transfer.
- **Wait states:** `HREADY`=0 for 5 cycles while master 1 drops and master 2 raises its request → no output change until the first `HREADY`=1 edge, then `M_HGRANT`=4'b0100.
- **Tenure limit:** master 0 holds its request with NONSEQ every cycle, master 3 requests, `MAX_TENURE`=16 → grant moves to master 3 exactly at the decision point after the 16th counted transfer.
- **Mid-transfer reset:** `rst` pulsed while master 2 owns the bus with `HREADY`=0 → outputs return to the `DEFAULT_MASTER` values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/ahb_arbiter_pkg.sv
// Shared definitions for the AHB arbiter: transfer types, FSM states,
// and the owner index width.
package ahb_defs;

   localparam int HMASTER_W = 4;

   typedef logic [HMASTER_W-1:0] hidx_t;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic {
      PARK = 1'b0,
      OWN  = 1'b1
   } state_t;

endpackage

// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the AHB masters' side and the arbiter.
// The arbiter connects through the slave modport.
interface ahb_arbiter_if
   import ahb_defs::*;
#(
   parameter int NUM_MASTERS = 4
);

   logic [NUM_MASTERS-1:0] M_HBUSREQ;
   logic                   HREADY;
   logic [1:0]             HTRANS;
   logic [NUM_MASTERS-1:0] M_HGRANT;
   hidx_t                  HMASTER;
   hidx_t                  HMASTER_D;

   modport master (
      output M_HBUSREQ, HREADY, HTRANS,
      input  M_HGRANT, HMASTER, HMASTER_D
   );

   modport slave (
      input  M_HBUSREQ, HREADY, HTRANS,
      output M_HGRANT, HMASTER, HMASTER_D
   );

endinterface

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit
// found walking upward from start, wrapping at N.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         valid
);

   always_comb begin
      int j;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(start) + i;
         if (j >= N) j = j - N;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = W'(j);
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with a parked default master and a tenure
// limit; publishes address- and data-phase owner indices.
module ahb_arbiter
   import ahb_defs::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_TENURE     = 16
) (
   input logic          clk,
   input logic          rst,
   ahb_arbiter_if.slave bus
);

   localparam hidx_t      DEF      = hidx_t'(DEFAULT_MASTER);
   localparam hidx_t      LAST_IDX = hidx_t'(NUM_MASTERS - 1);
   localparam logic [7:0] TEN_MAX  = 8'(MAX_TENURE);

   typedef logic [NUM_MASTERS-1:0] vec_t;

   state_t     state, state_n;
   hidx_t      cur, cur_n;
   hidx_t      last, last_n;
   hidx_t      hm, hm_n;
   hidx_t      hmd, hmd_n;
   logic [7:0] tenure, tenure_n;
   vec_t       grant;
   vec_t       req, pick_req;
   hidx_t      pick_start, pick_idx;
   logic       pick_valid, counted, rearb;

   function automatic hidx_t wrap_inc(hidx_t i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   function automatic vec_t onehot(hidx_t i);
      return vec_t'(1) << i;
   endfunction

   assign req     = bus.M_HBUSREQ;
   assign counted = (bus.HTRANS == HTRANS_NONSEQ) ||
                    (bus.HTRANS == HTRANS_SEQ);

   // The current owner is masked out so it can never re-win its own slot.
   assign pick_start = (state == PARK) ? wrap_inc(last) : wrap_inc(cur);
   assign pick_req   = (state == PARK) ? req : (req & ~onehot(cur));
   assign rearb      = !req[cur] ||
                       ((tenure == TEN_MAX) && (|pick_req));

   rr_pick #(
      .N (NUM_MASTERS),
      .W (HMASTER_W)
   ) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      state_n  = state;
      cur_n    = cur;
      last_n   = last;
      tenure_n = tenure;
      hm_n     = hm;
      hmd_n    = hmd;
      if (bus.HREADY) begin
         hm_n  = cur;
         hmd_n = hm;
         unique case (state)
            PARK: begin
               if (pick_valid) begin
                  state_n  = OWN;
                  cur_n    = pick_idx;
                  last_n   = pick_idx;
                  tenure_n = '0;
               end
            end
            OWN: begin
               if (rearb) begin
                  tenure_n = '0;
                  if (pick_valid) begin
                     cur_n  = pick_idx;
                     last_n = pick_idx;
                  end else begin
                     state_n = PARK;
                     cur_n   = DEF;
                  end
               end else if (counted && (tenure < TEN_MAX)) begin
                  tenure_n = tenure + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= PARK;
         cur    <= DEF;
         last   <= DEF;
         tenure <= '0;
         grant  <= onehot(DEF);
         hm     <= DEF;
         hmd    <= DEF;
      end else begin
         state  <= state_n;
         cur    <= cur_n;
         last   <= last_n;
         tenure <= tenure_n;
         grant  <= onehot(cur_n);
         hm     <= hm_n;
         hmd    <= hmd_n;
      end
   end

   assign bus.M_HGRANT  = grant;
   assign bus.HMASTER   = hm;
   assign bus.HMASTER_D = hmd;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: directed steps push expected
// grant/owner values, a monitor pops and compares them.
module tb_ahb_arbiter;

   logic clk;
   logic rst;

   ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

   ahb_arbiter #(
      .NUM_MASTERS    (4),
      .DEFAULT_MASTER (0),
      .MAX_TENURE     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] SQ = 2'b11;

   logic [11:0] exp_q[$];
   string       tag_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   event        ev_async;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   // Monitor: compares at every negedge, and on demand mid-cycle.
   initial begin
      logic [11:0] e;
      logic [11:0] a;
      string       t;
      forever begin
         @(negedge clk or ev_async);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {bus.M_HGRANT, bus.HMASTER, bus.HMASTER_D};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL %s: got grant=%b hm=%0d hmd=%0d want grant=%b hm=%0d hmd=%0d",
                        t, a[11:8], a[7:4], a[3:0], e[11:8], e[7:4], e[3:0]);
            end
         end
      end
   end

   task automatic step(input logic r, input logic [3:0] rq,
                       input logic rdy, input logic [1:0] tr,
                       input logic [3:0] eg, input logic [3:0] eh,
                       input logic [3:0] ed, input string tag);
      @(negedge clk);
      #1;
      rst           = r;
      bus.M_HBUSREQ = rq;
      bus.HREADY    = rdy;
      bus.HTRANS    = tr;
      exp_q.push_back({eg, eh, ed});
      tag_q.push_back(tag);
   endtask

   initial begin
      rst           = 1'b1;
      bus.M_HBUSREQ = 4'b0000;
      bus.HREADY    = 1'b1;
      bus.HTRANS    = ID;

      step(1, 4'b0000, 1, ID, 4'b0001, 0, 0, "reset_held");
      step(1, 4'b0000, 1, ID, 4'b0001, 0, 0, "reset_held");
      for (int i = 0; i < 10; i++)
         step(0, 4'b0000, 1, ID, 4'b0001, 0, 0, "idle_park");

      step(0, 4'b0100, 1, ID, 4'b0100, 0, 0, "single_grant");
      step(0, 4'b0100, 1, NS, 4'b0100, 2, 0, "single_hm");
      step(0, 4'b0100, 1, NS, 4'b0100, 2, 2, "single_hmd");
      step(0, 4'b0000, 1, ID, 4'b0001, 2, 2, "single_park");
      step(0, 4'b0000, 1, ID, 4'b0001, 0, 2, "single_park");
      step(0, 4'b0000, 1, ID, 4'b0001, 0, 0, "single_park");

      step(0, 4'b0001, 1, ID, 4'b0001, 0, 0, "last0_own");
      step(0, 4'b0000, 1, ID, 4'b0001, 0, 0, "last0_park");
      step(0, 4'b1011, 1, NS, 4'b0010, 0, 0, "simul_m1");
      step(0, 4'b1011, 1, NS, 4'b0010, 1, 0, "simul_m1_xfer");
      step(0, 4'b1001, 1, ID, 4'b1000, 1, 1, "simul_m3");
      step(0, 4'b1001, 1, SQ, 4'b1000, 3, 1, "simul_m3_xfer");
      step(0, 4'b0001, 1, ID, 4'b0001, 3, 3, "simul_m0");
      step(0, 4'b0001, 1, NS, 4'b0001, 0, 3, "simul_m0_xfer");
      step(0, 4'b0000, 1, ID, 4'b0001, 0, 0, "simul_park");

      step(0, 4'b0010, 1, ID, 4'b0010, 0, 0, "wait_m1");
      step(0, 4'b0010, 1, NS, 4'b0010, 1, 0, "wait_m1_xfer");
      step(0, 4'b0010, 0, NS, 4'b0010, 1, 0, "wait_hold");
      step(0, 4'b0110, 0, NS, 4'b0010, 1, 0, "wait_hold");
      step(0, 4'b0100, 0, NS, 4'b0010, 1, 0, "wait_hold");
      step(0, 4'b0100, 0, NS, 4'b0010, 1, 0, "wait_hold");
      step(0, 4'b0100, 0, NS, 4'b0010, 1, 0, "wait_hold");
      step(0, 4'b0100, 1, ID, 4'b0100, 1, 1, "wait_m2");
      step(0, 4'b0100, 1, NS, 4'b0100, 2, 1, "wait_m2_hm");

      step(0, 4'b0000, 1, ID, 4'b0001, 2, 2, "ten_park");
      step(0, 4'b0001, 1, NS, 4'b0001, 0, 2, "ten_m0");
      for (int k = 1; k <= 16; k++)
         step(0, 4'b1001, 1, NS, 4'b0001, 0, 0, "ten_hold");
      step(0, 4'b1001, 1, NS, 4'b1000, 0, 0, "ten_switch");
      step(0, 4'b1001, 1, NS, 4'b1000, 3, 0, "ten_m3");
      step(0, 4'b0001, 1, ID, 4'b0001, 3, 3, "ten_back_m0");

      step(0, 4'b0100, 1, ID, 4'b0100, 0, 3, "rst_m2");
      step(0, 4'b0100, 1, NS, 4'b0100, 2, 0, "rst_m2_xfer");
      step(0, 4'b0100, 0, NS, 4'b0100, 2, 0, "rst_m2_wait");
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.push_back({4'b0001, 4'd0, 4'd0});
      tag_q.push_back("async_reset");
      -> ev_async;
      #1;
      step(1, 4'b0100, 0, NS, 4'b0001, 0, 0, "reset_again");
      step(0, 4'b1000, 1, ID, 4'b1000, 0, 0, "post_reset_m3");

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
